// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, FSM state type and candidate-mask helpers
package sudoku_pkg;

  localparam int CELL_W = 9;
  localparam int N = 9;
  localparam logic [CELL_W-1:0] ALL_CAND = 9'h1FF;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_READY,
    ST_SCAN,
    ST_COMMIT,
    ST_DRAIN
  } state_t;

  // Exactly one candidate left in the mask.
  function automatic logic is_onehot(input logic [CELL_W-1:0] mask);
    return (mask != '0) && ((mask & (mask - 9'd1)) == '0);
  endfunction

  // Givens 1..9 become a single candidate; 0 and 10..15 mean unknown.
  function automatic logic [CELL_W-1:0] digit_to_mask(input logic [3:0] digit);
    logic [CELL_W-1:0] mask;
    mask = ALL_CAND;
    if ((digit >= 4'd1) && (digit <= 4'd9)) mask = 9'(1) << (digit - 4'd1);
    return mask;
  endfunction

  // Determined cells report their digit; anything else reads back as 0.
  function automatic logic [3:0] mask_to_digit(input logic [CELL_W-1:0] mask);
    logic [3:0] digit;
    digit = 4'd0;
    for (int i = 0; i < CELL_W; i++) begin
      if (mask[i]) digit = 4'(i + 1);
    end
    if (!is_onehot(mask)) digit = 4'd0;
    return digit;
  endfunction

endpackage

// File: rtl/solve_controller_if.sv
// rtl/solve_controller_if.sv - load and readout digit stream handshakes
interface solve_controller_if;
  logic       load_valid;
  logic [3:0] load_digit;
  logic       load_ready;
  logic       read_valid;
  logic [3:0] read_digit;
  logic       read_ready;

  modport master (
    output load_valid, load_digit, read_ready,
    input  load_ready, read_valid, read_digit
  );

  modport slave (
    input  load_valid, load_digit, read_ready,
    output load_ready, read_valid, read_digit
  );
endinterface

// File: rtl/solve_controller_box_unpack.sv
// rtl/solve_controller_box_unpack.sv - remap box-major scanner grid to [col][row]
module box_unpack
  import sudoku_pkg::*;
(
  input  logic [2:0][2:0][N-1:0][CELL_W-1:0] i_box,
  output logic [N-1:0][N-1:0][CELL_W-1:0]    o_grid
);

  // Cell (3*bc+c, 3*br+r) lives at slot k = 3*r + c inside box (bc, br).
  for (genvar bc = 0; bc < 3; bc++) begin : g_bc
    for (genvar br = 0; br < 3; br++) begin : g_br
      for (genvar r = 0; r < 3; r++) begin : g_r
        for (genvar c = 0; c < 3; c++) begin : g_c
          assign o_grid[3*bc+c][3*br+r] = i_box[bc][br][3*r+c];
        end
      end
    end
  end

endmodule

// File: rtl/solve_controller.sv
// rtl/solve_controller.sv - candidate grid owner: load, iterate scanner passes, drain
module solve_controller
  import sudoku_pkg::*;
#(
  parameter int SCAN_LATENCY = 2,
  parameter int MAX_PASSES   = 64
) (
  input  logic                               i_Clk,
  input  logic                               i_Reset,
  solve_controller_if.slave                  bus,
  input  logic                               i_Start,
  output logic [N-1:0][N-1:0][CELL_W-1:0]    o_Scan_Grid,
  input  logic [2:0][2:0][N-1:0][CELL_W-1:0] i_Scan_Grid,
  input  logic                               i_Scan_Complete,
  output logic                               o_Busy,
  output logic                               o_Solved,
  output logic                               o_Stuck,
  output logic                               o_Error,
  output logic [7:0]                         o_Pass_Count
);

  state_t                          state_q, state_d;
  logic [N-1:0][N-1:0][CELL_W-1:0] grid_q, grid_d;
  logic [3:0]                      row_q, row_d, col_q, col_d;
  logic [3:0]                      wait_q, wait_d;
  logic [7:0]                      pass_q, pass_d;
  logic                            solved_q, solved_d, stuck_q, stuck_d, error_q, error_d;
  logic                            busy_q, busy_d, load_ready_q, load_ready_d;
  logic                            read_valid_q, read_valid_d;
  logic [3:0]                      read_digit_q, read_digit_d;

  logic [N-1:0][N-1:0][CELL_W-1:0] scan_remap;
  logic                            load_fire, read_fire, last_cell, any_zero, all_onehot;
  logic [3:0]                      row_inc, col_inc;

  box_unpack u_box_unpack (
    .i_box  (i_Scan_Grid),
    .o_grid (scan_remap)
  );

  // Next-state, grid update, pass evaluation and readout sequencing.
  always_comb begin
    state_d      = state_q;
    grid_d       = grid_q;
    row_d        = row_q;
    col_d        = col_q;
    wait_d       = wait_q;
    pass_d       = pass_q;
    solved_d     = solved_q;
    stuck_d      = stuck_q;
    error_d      = error_q;
    read_valid_d = read_valid_q;
    read_digit_d = read_digit_q;

    load_fire = bus.load_valid && load_ready_q;
    read_fire = read_valid_q && bus.read_ready;
    last_cell = (row_q == 4'd8) && (col_q == 4'd8);
    col_inc   = (col_q == 4'd8) ? 4'd0 : col_q + 4'd1;
    row_inc   = (col_q != 4'd8) ? row_q : ((row_q == 4'd8) ? 4'd0 : row_q + 4'd1);

    any_zero   = 1'b0;
    all_onehot = 1'b1;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) begin
        if (scan_remap[c][r] == '0) any_zero = 1'b1;
        if (!is_onehot(scan_remap[c][r])) all_onehot = 1'b0;
      end
    end

    case (state_q)
      ST_LOAD: begin
        if (load_fire) begin
          grid_d[col_q][row_q] = digit_to_mask(bus.load_digit);
          col_d = col_inc;
          row_d = row_inc;
          if ((row_q == 4'd0) && (col_q == 4'd0)) begin
            solved_d = 1'b0;
            stuck_d  = 1'b0;
            error_d  = 1'b0;
            pass_d   = 8'd0;
          end
          if (last_cell) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (i_Start) begin
          state_d = ST_SCAN;
          wait_d  = 4'd0;
        end
      end
      ST_SCAN: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == 4'(SCAN_LATENCY - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        grid_d = scan_remap;
        pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
        wait_d = 4'd0;
        if (any_zero) begin
          error_d = 1'b1;
          state_d = ST_DRAIN;
        end else if (i_Scan_Complete || all_onehot) begin
          solved_d = 1'b1;
          state_d  = ST_DRAIN;
        end else if (scan_remap == grid_q) begin
          stuck_d = 1'b1;
          state_d = ST_DRAIN;
        end else if (({1'b0, pass_q} + 9'd1) == 9'(MAX_PASSES)) begin
          stuck_d = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SCAN;
        end
        // Cell 0 is presented in the same cycle the status flags appear.
        if (state_d == ST_DRAIN) begin
          read_valid_d = 1'b1;
          read_digit_d = mask_to_digit(scan_remap[0][0]);
          col_d        = 4'd0;
          row_d        = 4'd0;
        end
      end
      ST_DRAIN: begin
        if (read_fire) begin
          col_d = col_inc;
          row_d = row_inc;
          if (last_cell) begin
            read_valid_d = 1'b0;
            read_digit_d = 4'd0;
            state_d      = ST_LOAD;
          end else begin
            read_digit_d = mask_to_digit(grid_q[col_inc][row_inc]);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    load_ready_d = (state_d == ST_LOAD);
    busy_d       = (state_d == ST_SCAN) || (state_d == ST_COMMIT);
  end

  // State and every output register; reset wins over all other activity.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= ST_LOAD;
      grid_q       <= {(N*N){ALL_CAND}};
      row_q        <= 4'd0;
      col_q        <= 4'd0;
      wait_q       <= 4'd0;
      pass_q       <= 8'd0;
      solved_q     <= 1'b0;
      stuck_q      <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b0;
      read_valid_q <= 1'b0;
      read_digit_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      grid_q       <= grid_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wait_q       <= wait_d;
      pass_q       <= pass_d;
      solved_q     <= solved_d;
      stuck_q      <= stuck_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
      read_valid_q <= read_valid_d;
      read_digit_q <= read_digit_d;
    end
  end

  assign o_Scan_Grid    = grid_q;
  assign o_Busy         = busy_q;
  assign o_Solved       = solved_q;
  assign o_Stuck        = stuck_q;
  assign o_Error        = error_q;
  assign o_Pass_Count   = pass_q;
  assign bus.load_ready = load_ready_q;
  assign bus.read_valid = read_valid_q;
  assign bus.read_digit = read_digit_q;

endmodule

// File: tb/tb_solve_controller.sv
// tb/tb_solve_controller.sv - scoreboard bench for solve_controller
module tb_solve_controller;

  localparam int LAT  = 2;
  localparam int MAXP = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [8:0][8:0][8:0]      scan_grid;
  logic [2:0][2:0][8:0][8:0] scan_in;
  logic                      scan_cmp;
  logic                      busy, solved, stuck, error_f;
  logic [7:0]                pass_cnt;
  logic [8:0]                mdl_m;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   mode = 1;
  bit   bp_en = 1'b0;
  int   bp_cnt = 0;

  logic [3:0]  exp_dq[$];
  logic [10:0] exp_sq[$];
  logic [3:0]  puz[81];

  solve_controller_if bus ();

  solve_controller #(
    .SCAN_LATENCY (LAT),
    .MAX_PASSES   (MAXP)
  ) dut (
    .i_Clk           (clk),
    .i_Reset         (rst),
    .bus             (bus),
    .i_Start         (start),
    .o_Scan_Grid     (scan_grid),
    .i_Scan_Grid     (scan_in),
    .i_Scan_Complete (scan_cmp),
    .o_Busy          (busy),
    .o_Solved        (solved),
    .o_Stuck         (stuck),
    .o_Error         (error_f),
    .o_Pass_Count    (pass_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sol(input int c, input int r);
    return ((r * 3 + r / 3 + c + 5) % 9) + 1;
  endfunction

  // Scanner model: 0 returns the solution, 1 echoes, 2 echoes with a zero mask, 3 flips one bit.
  always_comb begin
    scan_in = '0;
    mdl_m   = '0;
    for (int c = 0; c < 9; c++) begin
      for (int r = 0; r < 9; r++) begin
        mdl_m = scan_grid[c][r];
        if (mode == 0) mdl_m = 9'(1) << (sol(c, r) - 1);
        else if (mode == 2 && c == 7 && r == 2) mdl_m = '0;
        else if (mode == 3 && c == 0 && r == 0) mdl_m = mdl_m ^ 9'h001;
        scan_in[c/3][r/3][3*(r%3) + (c%3)] = mdl_m;
      end
    end
  end
  assign scan_cmp = (mode == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load_ready(input string name);
    int n;
    n = 0;
    while (bus.load_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check(name, bus.load_ready, 1);
  endtask

  task automatic load_puzzle();
    wait_load_ready("load_ready_wait");
    for (int n = 0; n < 81; n++) begin
      bus.load_valid = 1'b1;
      bus.load_digit = puz[n];
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_digit = 4'd0;
  endtask

  task automatic run_solve(input int exp_cyc);
    int cyc;
    cyc   = 0;
    start = 1'b1;
    do begin
      tick();
      cyc++;
      if (cyc == 1) start = 1'b0;
    end while (!(solved || stuck || error_f) && cyc < 500);
    check("solve_latency", cyc, exp_cyc);
  endtask

  task automatic finish_drain();
    wait_load_ready("drain_done");
    check("digit_queue_empty", exp_dq.size(), 0);
    check("status_queue_empty", exp_sq.size(), 0);
  endtask

  // Readout consumer: always ready, or toggling every 3 cycles.
  initial begin
    bus.read_ready = 1'b1;
    forever begin
      tick();
      if (bp_en) begin
        bp_cnt++;
        if (bp_cnt == 3) begin
          bp_cnt = 0;
          bus.read_ready = ~bus.read_ready;
        end
      end else begin
        bus.read_ready = 1'b1;
      end
    end
  end

  // Monitor: status on the first readout cycle, every accepted digit, and stall holding.
  initial begin
    logic        pv, pr;
    logic [3:0]  pd, e;
    logic [10:0] es;
    int          idx;
    pv = 1'b0; pr = 1'b0; pd = 4'd0; idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", bus.read_valid, 1);
          check($sformatf("hold_digit%0d", idx), bus.read_digit, pd);
        end
        if (bus.read_valid && !pv) begin
          idx = 0;
          if (exp_sq.size() == 0) begin
            vec_cnt++; err_cnt++;
            $display("FAIL status_extra: got %0h expected none", {solved, stuck, error_f, pass_cnt});
          end else begin
            es = exp_sq.pop_front();
            check("status", {solved, stuck, error_f, pass_cnt}, es);
          end
        end
        if (bus.read_valid && bus.read_ready) begin
          if (exp_dq.size() == 0) begin
            vec_cnt++; err_cnt++;
            $display("FAIL digit_extra: got %0h expected none", bus.read_digit);
          end else begin
            e = exp_dq.pop_front();
            check($sformatf("digit%0d", idx), bus.read_digit, e);
          end
          idx++;
        end
        pv = bus.read_valid;
        pr = bus.read_ready;
        pd = bus.read_digit;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_digit = 4'd0;

    // Reset held for two cycles.
    tick();
    tick();
    rst = 1'b0;
    check("rst_load_ready_reset_cycle", bus.load_ready, 0);
    tick();
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_grid_all_cand", (scan_grid === {81{9'h1FF}}), 1);
    check("rst_flags", {busy, solved, stuck, error_f}, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_read_valid", bus.read_valid, 0);

    // Solved in one pass, one blank at (4,4) = 5, readout under backpressure.
    mode = 0;
    for (int n = 0; n < 81; n++) puz[n] = 4'(sol(n % 9, n / 9));
    puz[40] = 4'd0;
    exp_sq.push_back({1'b1, 1'b0, 1'b0, 8'd1});
    for (int n = 0; n < 81; n++) exp_dq.push_back(4'(sol(n % 9, n / 9)));
    load_puzzle();
    bp_en = 1'b1;
    run_solve(LAT + 2);
    finish_drain();
    bp_en = 1'b0;

    // All unknown plus an out-of-range digit, echo scanner: stuck after one pass.
    mode = 1;
    for (int n = 0; n < 81; n++) puz[n] = 4'd0;
    puz[10] = 4'd12;
    exp_sq.push_back({1'b0, 1'b1, 1'b0, 8'd1});
    for (int n = 0; n < 81; n++) exp_dq.push_back(4'd0);
    load_puzzle();
    run_solve(LAT + 2);
    finish_drain();

    // Zero mask at (7,2): error wins, cell 25 and the blank read back 0.
    mode = 2;
    for (int n = 0; n < 81; n++) puz[n] = 4'(sol(n % 9, n / 9));
    puz[40] = 4'd0;
    exp_sq.push_back({1'b0, 1'b0, 1'b1, 8'd1});
    for (int n = 0; n < 81; n++) exp_dq.push_back((n == 25 || n == 40) ? 4'd0 : 4'(sol(n % 9, n / 9)));
    load_puzzle();
    run_solve(LAT + 2);
    finish_drain();

    // Scanner always changes one bit: stuck on the pass limit.
    mode = 3;
    for (int n = 0; n < 81; n++) puz[n] = 4'd0;
    exp_sq.push_back({1'b0, 1'b1, 1'b0, 8'(MAXP)});
    for (int n = 0; n < 81; n++) exp_dq.push_back(4'd0);
    load_puzzle();
    run_solve(MAXP * (LAT + 1) + 1);
    finish_drain();

    // Reset while scanning.
    mode = 1;
    for (int n = 0; n < 81; n++) puz[n] = 4'(sol(n % 9, n / 9));
    load_puzzle();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy_before_reset", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_flags", {busy, solved, stuck, error_f}, 0);
    check("mid_pass", pass_cnt, 0);
    check("mid_read_valid", bus.read_valid, 0);
    check("mid_grid_all_cand", (scan_grid === {81{9'h1FF}}), 1);
    tick();
    check("mid_load_ready", bus.load_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
